// File: rtl/display_scan_controller.sv
// Four-digit multiplexed display scanner with double-dabble BCD conversion once per frame.
// Optional LEADING_ZERO_BLANK_EN turns off anodes of leading zero digits (units never blanked).
module display_scan_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic       scan_tick,
  input  logic       control,
  input  logic [2:0] cod_frecuencia,
  input  logic [9:0] corriente,
  output logic [3:0] selec_digito,
  output logic [3:0] digito,
  output logic       conv_busy
);

  localparam int unsigned VAL_W  = 10;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned ITER_W = 4;
  localparam int unsigned IDX_W  = 2;
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(VAL_W - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [VAL_W-1:0]  sreg, sreg_n;
  logic [BCD_W-1:0]  acc, acc_n, adj;
  logic [ITER_W-1:0] iter, iter_n;
  logic [BCD_W-1:0]  buffer, buffer_n;
  logic              valid, valid_n;
  logic [BCD_W-1:0]  frame;
  logic              frame_valid;
  logic [VAL_W-1:0]  freq_val, src_val;
  logic [BCD_W-1:0]  show_buf, show_shifted;
  logic              show_valid, blank;
  logic [3:0]        anode, nib;

  // Frequency code to displayed value
  always_comb begin
    freq_val = VAL_W'(0);
    case (cod_frecuencia)
      3'd0: freq_val = VAL_W'(10);
      3'd1: freq_val = VAL_W'(20);
      3'd2: freq_val = VAL_W'(50);
      3'd3: freq_val = VAL_W'(100);
      3'd4: freq_val = VAL_W'(200);
      3'd5: freq_val = VAL_W'(300);
      3'd6: freq_val = VAL_W'(500);
      default: freq_val = VAL_W'(1000);
    endcase
  end

  assign src_val = control ? freq_val : corriente;

  // Add-3 correction applied to every BCD nibble before each shift
  always_comb begin
    adj = acc;
    for (int i = 0; i < 4; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_n  = state;
    sreg_n   = sreg;
    acc_n    = acc;
    iter_n   = iter;
    buffer_n = buffer;
    valid_n  = valid;
    case (state)
      IDLE: begin
        if (scan_tick && (idx == IDX_W'(3))) state_n = LOAD;
      end
      LOAD: begin
        sreg_n  = src_val;
        acc_n   = BCD_W'(0);
        iter_n  = ITER_W'(0);
        state_n = SHIFT;
      end
      SHIFT: begin
        acc_n  = {adj[BCD_W-2:0], sreg[VAL_W-1]};
        sreg_n = {sreg[VAL_W-2:0], 1'b0};
        iter_n = iter + ITER_W'(1);
        if (iter == LAST_ITER) state_n = DONE;
      end
      DONE: begin
        buffer_n = acc;
        valid_n  = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // A new frame (index 0) latches the latest buffer so frames never mix conversions
  always_comb begin
    idx_n        = idx + IDX_W'(1);
    show_buf     = (idx_n == IDX_W'(0)) ? buffer : frame;
    show_valid   = (idx_n == IDX_W'(0)) ? valid : frame_valid;
    show_shifted = show_buf >> {idx_n, 2'b00};
    nib          = 4'(show_shifted);
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx_n != IDX_W'(0)) && (show_shifted == BCD_W'(0));
`else
    blank = 1'b0;
`endif
    anode = (show_valid && !blank) ? ~(4'b0001 << idx_n) : 4'b1111;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= IDX_W'(3);
      sreg         <= VAL_W'(0);
      acc          <= BCD_W'(0);
      iter         <= ITER_W'(0);
      buffer       <= BCD_W'(0);
      valid        <= 1'b0;
      frame        <= BCD_W'(0);
      frame_valid  <= 1'b0;
      selec_digito <= 4'b1111;
      digito       <= 4'd0;
      conv_busy    <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      acc       <= acc_n;
      iter      <= iter_n;
      buffer    <= buffer_n;
      valid     <= valid_n;
      conv_busy <= (state_n != IDLE);
      if (scan_tick) begin
        idx          <= idx_n;
        selec_digito <= anode;
        digito       <= nib;
        if (idx_n == IDX_W'(0)) begin
          frame       <= buffer;
          frame_valid <= valid;
        end
      end
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: directed scenarios plus random frames against a digit-level model.
module tb_display_scan_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       scan_tick;
  logic       control;
  logic [2:0] cod_frecuencia;
  logic [9:0] corriente;
  logic [3:0] selec_digito;
  logic [3:0] digito;
  logic       conv_busy;

  always #5 clock = ~clock;

  display_scan_controller dut (
    .clock(clock), .reset(reset), .scan_tick(scan_tick), .control(control),
    .cod_frecuencia(cod_frecuencia), .corriente(corriente),
    .selec_digito(selec_digito), .digito(digito), .conv_busy(conv_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: digit position, last finished value, value shown by the current frame
  int m_idx;
  int m_result;
  bit m_result_valid;
  int m_frame;
  bit m_frame_valid;
  int freq_tab[8] = '{10, 20, 50, 100, 200, 300, 500, 1000};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pow10(input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [3:0] exp_digit();
    return 4'((m_frame / pow10(m_idx)) % 10);
  endfunction

  function automatic logic [3:0] exp_anode();
    logic [3:0] a;
    a = 4'b1111;
    if (m_frame_valid) begin
      a[m_idx] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (m_idx > 0 && m_frame < pow10(m_idx)) a = 4'b1111;
`endif
    end
    return a;
  endfunction

  function automatic void model_reset();
    m_idx = 3; m_result = 0; m_result_valid = 0; m_frame = 0; m_frame_valid = 0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"}, 16'(selec_digito), 16'hF);
    check({tag, "_dig"}, 16'(digito), 16'h0);
    check({tag, "_busy"}, 16'(conv_busy), 16'h0);
  endtask

  // One scan strobe, then gap idle clocks; optionally change corriente chg_at clocks later
  task automatic tick(input int gap, input int chg_at, input logic [9:0] chg_val);
    bit trig;
    int pending;
    @(negedge clock);
    scan_tick = 1'b1;
    trig = (m_idx == 3);
    pending = control ? freq_tab[cod_frecuencia] : int'(corriente);
    @(posedge clock);
    #1 scan_tick = 1'b0;
    m_idx = (m_idx + 1) % 4;
    if (m_idx == 0) begin
      m_frame = m_result;
      m_frame_valid = m_result_valid;
    end
    if (trig) begin
      m_result = pending;
      m_result_valid = 1'b1;
    end
    check($sformatf("sel_i%0d", m_idx), 16'(selec_digito), 16'(exp_anode()));
    check($sformatf("dig_i%0d", m_idx), 16'(digito), 16'(exp_digit()));
    check("busy_at_tick", 16'(conv_busy), 16'(trig));
    for (int c = 1; c <= gap; c++) begin
      @(posedge clock);
      #1;
      if (c == chg_at) corriente = chg_val;
      if (trig && c == 11) check("busy_c11", 16'(conv_busy), 16'h1);
      if (trig && c == 12) check("busy_c12", 16'(conv_busy), 16'h0);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick(16, -1, 10'd0);
  endtask

  initial begin
    reset = 1'b1; scan_tick = 1'b0; control = 1'b0; cod_frecuencia = 3'd0; corriente = 10'd0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 check_reset_outputs("rst");
    @(negedge clock) reset = 1'b0;

    // Full-scale current: 1023
    corriente = 10'd1023;
    ticks(8);

    // Frequency code 2 -> 50
    control = 1'b1; cod_frecuencia = 3'd2;
    ticks(8);

    // Zero current
    control = 1'b0; corriente = 10'd0;
    ticks(8);

    // Input change during SHIFT must not affect the running conversion
    corriente = 10'd7;
    tick(16, 4, 10'd512);
    ticks(11);

    // Reset during SHIFT iteration 5 aborts conversion
    @(negedge clock) scan_tick = 1'b1;
    @(posedge clock);
    #1 scan_tick = 1'b0;
    repeat (6) @(posedge clock);
    #1 check("busy_shift", 16'(conv_busy), 16'h1);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1 check_reset_outputs("abort");
    model_reset();
    @(negedge clock) reset = 1'b0;
    repeat (16) @(posedge clock);
    ticks(8);

    // Reset and scan_tick in the same cycle: reset wins, index stays 3
    @(negedge clock) begin reset = 1'b1; scan_tick = 1'b1; end
    @(posedge clock);
    #1 check_reset_outputs("rst_tick");
    model_reset();
    @(negedge clock) begin reset = 1'b0; scan_tick = 1'b0; end
    repeat (16) @(posedge clock);
    corriente = 10'd305;
    ticks(8);

    // Random frames
    for (int r = 0; r < 12; r++) begin
      control = 1'($urandom_range(0, 1));
      cod_frecuencia = 3'($urandom_range(0, 7));
      corriente = 10'($urandom_range(0, 1023));
      for (int k = 0; k < 4; k++) tick(int'($urandom_range(15, 20)), -1, 10'd0);
    end
    ticks(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
